// File: rtl/oam_dma_arbiter.sv
// Sprite DMA controller and CPU/DMA bus arbiter: a CPU write to DMA_REG_ADDR halts the CPU and copies a page to OAM.
// Optional build macro OAM_DMA_STAT_EN adds the dma_stall_cnt debug counter output.
module oam_dma_arbiter #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int          XFER_LEN      = 256
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_rw,
    input  logic [7:0]  bus_din,
    output logic        rdy,
    output logic [15:0] bus_a,
    output logic [7:0]  bus_dout,
    output logic        bus_rw,
    output logic        dma_busy
`ifdef OAM_DMA_STAT_EN
    ,
    output logic [15:0] dma_stall_cnt
`endif
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_HALT = 3'd1;
    localparam logic [2:0] ALIGN     = 3'd2;
    localparam logic [2:0] READ      = 3'd3;
    localparam logic [2:0] WRITE     = 3'd4;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    logic [2:0] state_q, state_d;
    logic       parity_q, parity_d;
    logic [7:0] page_q, page_d;
    logic [7:0] index_q, index_d;
    logic [7:0] buf_q, buf_d;
    logic       rdy_q, rdy_d;
    logic       busy_q, busy_d;
    logic       trigger;

    assign trigger = !cpu_rw && (cpu_a == DMA_REG_ADDR);

    always_comb begin
        state_d  = state_q;
        parity_d = ~parity_q;
        page_d   = page_q;
        index_d  = index_q;
        buf_d    = buf_q;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    page_d  = cpu_dout;
                    index_d = 8'd0;
                    state_d = WAIT_HALT;
                end
            end
            WAIT_HALT: begin
                // The first CPU read is the halt cycle; reads must land on get (parity 0) cycles.
                if (cpu_rw) begin
                    state_d = parity_q ? READ : ALIGN;
                end else if (trigger) begin
                    page_d = cpu_dout;
                end
            end
            ALIGN: state_d = READ;
            READ: begin
                buf_d   = bus_din;
                state_d = WRITE;
            end
            WRITE: begin
                if (index_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    index_d = index_q + 8'd1;
                    state_d = READ;
                end
            end
            default: state_d = IDLE;
        endcase
        rdy_d  = (state_d == IDLE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state_q  <= IDLE;
            parity_q <= 1'b0;
            page_q   <= 8'd0;
            index_q  <= 8'd0;
            buf_q    <= 8'd0;
            rdy_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            parity_q <= parity_d;
            page_q   <= page_d;
            index_q  <= index_d;
            buf_q    <= buf_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        bus_a    = cpu_a;
        bus_dout = cpu_dout;
        bus_rw   = cpu_rw;
        case (state_q)
            READ: begin
                bus_a    = {page_q, index_q};
                bus_dout = 8'h00;
                bus_rw   = 1'b1;
            end
            WRITE: begin
                bus_a    = OAM_DATA_ADDR;
                bus_dout = buf_q;
                bus_rw   = 1'b0;
            end
            default: ;
        endcase
    end

    assign rdy      = rdy_q;
    assign dma_busy = busy_q;

`ifdef OAM_DMA_STAT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (!rdy_q && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign dma_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Scoreboard bench for oam_dma_arbiter: randomized pages/data, reference of DMA bus cycles pushed at trigger time.
`timescale 1ns/1ps
module tb_oam_dma_arbiter;

    logic        CLK = 1'b0;
    logic        RES = 1'b1;
    logic [15:0] cpu_a = 16'hC123;
    logic [7:0]  cpu_dout = 8'h00;
    logic        cpu_rw = 1'b1;
    logic [7:0]  bus_din;
    logic        rdy, bus_rw, dma_busy;
    logic [15:0] bus_a;
    logic [7:0]  bus_dout;

    logic [15:0] cpu_a4 = 16'hC123;
    logic [7:0]  cpu_dout4 = 8'h00;
    logic        cpu_rw4 = 1'b1;
    logic [7:0]  bus_din4;
    logic        rdy4, bus_rw4, dma_busy4;
    logic [15:0] bus_a4;
    logic [7:0]  bus_dout4;
`ifdef OAM_DMA_STAT_EN
    logic [15:0] dma_stall_cnt, dma_stall_cnt4;
`endif

    logic [7:0] mem [0:65535];
    assign bus_din  = mem[bus_a];
    assign bus_din4 = mem[bus_a4];

    oam_dma_arbiter u_dut (
        .CLK(CLK), .RES(RES), .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_rw(cpu_rw),
        .bus_din(bus_din), .rdy(rdy), .bus_a(bus_a), .bus_dout(bus_dout),
        .bus_rw(bus_rw), .dma_busy(dma_busy)
`ifdef OAM_DMA_STAT_EN
        , .dma_stall_cnt(dma_stall_cnt)
`endif
    );

    oam_dma_arbiter #(.XFER_LEN(4)) u_dut4 (
        .CLK(CLK), .RES(RES), .cpu_a(cpu_a4), .cpu_dout(cpu_dout4), .cpu_rw(cpu_rw4),
        .bus_din(bus_din4), .rdy(rdy4), .bus_a(bus_a4), .bus_dout(bus_dout4),
        .bus_rw(bus_rw4), .dma_busy(dma_busy4)
`ifdef OAM_DMA_STAT_EN
        , .dma_stall_cnt(dma_stall_cnt4)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        wr;
        logic [15:0] a;
        logic [7:0]  d;
    } ev_t;

    ev_t         exp_q[$];
    logic [15:0] a4_q[$];
    logic [7:0]  d4_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc;
    int          low_cnt = 0;
    int          low4_cnt = 0;
    int          oam_wr_cnt = 0;
    int          exp_stall = 0;
    bit          mon_en = 1'b1;

    // Bench view of the get/put phase: cycles elapsed since reset release.
    always @(posedge CLK or posedge RES) begin
        if (RES) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge CLK) begin
        if (!RES && !rdy)  low_cnt++;
        if (!RES && !rdy4) low4_cnt++;
        if (!RES && !bus_rw && bus_a == 16'h2004 && cpu_rw) oam_wr_cnt++;
        if (!RES && !bus_rw4 && cpu_rw4) begin
            a4_q.push_back(bus_a4);
            d4_q.push_back(bus_dout4);
        end
    end

    // Monitor: any bus cycle not owned by the (halted, reading C123) CPU is a DMA cycle.
    always @(negedge CLK) begin : monitor
        ev_t e;
        if (mon_en && !RES && dma_busy && cpu_rw && (!bus_rw || bus_a != cpu_a)) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_extra: got wr=%b a=%h d=%h, expected no DMA cycle", !bus_rw, bus_a, bus_dout);
            end else begin
                e = exp_q.pop_front();
                if (e.wr !== !bus_rw || e.a !== bus_a || e.d !== bus_dout) begin
                    miscompares++;
                    $display("FAIL sb_cycle: got wr=%b a=%h d=%h, expected wr=%b a=%h d=%h",
                             !bus_rw, bus_a, bus_dout, e.wr, e.a, e.d);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // First get cycle after the halt cycle h; reads start there and the transfer takes 2*len cycles.
    function automatic int exp_low_cycles(input int t, input int h, input int len);
        int rstart;
        rstart = ((h + 1) % 2 == 0) ? h + 1 : h + 2;
        return rstart + 2 * len - 1 - t;
    endfunction

    task automatic run_dma(input logic [7:0] page, input int par, input int nwr, input bit abort);
        int  t, h, rstart, exp_low, busy_bad;
        bit  done;
        for (int i = 0; i < 256; i++) mem[{page, 8'(i)}] = 8'($urandom);
        while (cyc % 2 != par) step();
        t = cyc;
        low_cnt = 0;
        cpu_a = 16'h4014; cpu_rw = 1'b0; cpu_dout = page;
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back('{1'b0, {page, 8'(i)}, 8'h00});
            exp_q.push_back('{1'b1, 16'h2004, mem[{page, 8'(i)}]});
        end
        #2;
        chk("trig_pass_a", bus_a, 16'h4014);
        chk("trig_pass_d", {bus_rw, bus_dout}, {1'b0, page});
        step();
        for (int k = 0; k < nwr; k++) begin
            cpu_a = 16'h0300 + 16'(k); cpu_dout = 8'h30 + 8'(k); cpu_rw = 1'b0;
            #2;
            chk("stall_pass", {bus_rw, bus_a, bus_dout, rdy, dma_busy}, {1'b0, cpu_a, cpu_dout, 1'b0, 1'b1});
            step();
        end
        h = cyc;
        cpu_a = 16'hC123; cpu_rw = 1'b1; cpu_dout = 8'h00;
        rstart = ((h + 1) % 2 == 0) ? h + 1 : h + 2;
        exp_low = exp_low_cycles(t, h, 256);
        if (abort) begin
            while (cyc < rstart + 198) step();
            #2 RES = 1'b1;
            mon_en = 1'b0;
            #1;
            chk("abort_rdy_busy", {rdy, dma_busy}, 2'b10);
            chk("abort_pass", {bus_rw, bus_a}, {1'b1, 16'hC123});
            exp_q.delete();
            exp_stall = 0;
            step(); step();
            RES = 1'b0;
            mon_en = 1'b1;
            oam_wr_cnt = 0;
            repeat (20) step();
            chk("no_oam_after_rst", oam_wr_cnt, 0);
            $display("dma page=%02h T=%0d aborted at read 100", page, t);
            return;
        end
        done = 1'b0;
        busy_bad = 0;
        for (int n = 0; n < 1200 && !done; n++) begin
            @(negedge CLK);
            if (dma_busy !== !rdy) busy_bad++;
            if (rdy) done = 1'b1;
        end
        chk("rdy_timeout", done, 1'b1);
        chk("busy_tracks_rdy", busy_bad, 0);
        step();
        chk("sb_drain", exp_q.size(), 0);
        chk("rdy_low_cycles", low_cnt, exp_low);
        exp_stall += exp_low;
`ifdef OAM_DMA_STAT_EN
        chk("stall_cnt", dma_stall_cnt, exp_stall);
`endif
        $display("dma page=%02h T=%0d par=%0d stalls=%0d rdy_low=%0d exp=%0d", page, t, par, nwr, low_cnt, exp_low);
        exp_q.delete();
    endtask

    function automatic logic [7:0] rand_page();
        logic [7:0] p;
        p = 8'($urandom);
        while (p == 8'hC1 || p == 8'hFF || p == 8'h03) p = 8'($urandom);
        return p;
    endfunction

    initial begin
        logic [7:0] pat [4];
        int t4, exp4;
        bit done4;
        pat = '{8'hA5, 8'h5A, 8'h00, 8'hFF};
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        step();
        chk("rst_rdy_busy", {rdy, dma_busy}, 2'b10);
        chk("rst_pass", {bus_rw, bus_a, bus_dout}, {1'b1, 16'hC123, 8'h00});
        step();
        RES = 1'b0;
        repeat (3) step();

        run_dma(rand_page(), 0, 0, 1'b0);
        run_dma(rand_page(), 1, 0, 1'b0);
        run_dma(rand_page(), int'($urandom_range(0, 1)), 2, 1'b0);
        run_dma(rand_page(), int'($urandom_range(0, 1)), 0, 1'b1);
        run_dma(rand_page(), 0, 0, 1'b0);
        run_dma(rand_page(), 1, 0, 1'b0);

        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) mem[{8'hFF, 8'(i)}] = pat[i];
            while (cyc % 2 != p) step();
            t4 = cyc;
            low4_cnt = 0;
            a4_q.delete(); d4_q.delete();
            cpu_a4 = 16'h4014; cpu_rw4 = 1'b0; cpu_dout4 = 8'hFF;
            step();
            cpu_a4 = 16'hC123; cpu_rw4 = 1'b1; cpu_dout4 = 8'h00;
            exp4 = exp_low_cycles(t4, t4 + 1, 4);
            done4 = 1'b0;
            for (int n = 0; n < 100 && !done4; n++) begin
                @(negedge CLK);
                if (rdy4) done4 = 1'b1;
            end
            chk("x4_timeout", done4, 1'b1);
            step();
            chk("x4_rdy_low", low4_cnt, exp4);
            chk("x4_nwrites", a4_q.size(), 4);
            for (int i = 0; i < 4 && i < a4_q.size(); i++) begin
                chk("x4_addr", a4_q[i], 16'h2004);
                chk("x4_data", d4_q[i], pat[i]);
            end
            $display("dma4 page=ff T=%0d par=%0d writes=%0d rdy_low=%0d exp=%0d", t4, p, a4_q.size(), low4_cnt, exp4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/oam_dma_arbiter.md
Name: oam_dma_arbiter

Overview:
Sprite DMA controller and bus arbiter for the 2A03 CPU core. It snoops CPU writes to $4014, halts the CPU through RDY, and takes over the shared address/data bus. It then copies a 256-byte page to the PPU OAM data port ($2004) as alternating read/write cycles. It sits between the CPU core's bus outputs and the system bus decoder.

Parameters:
DMA_REG_ADDR, 16'h4014, CPU write address that triggers a DMA; the written byte is the source page.
OAM_DATA_ADDR, 16'h2004, destination address for every DMA write cycle.
XFER_LEN, 256, bytes per DMA, legal range 1..256; the index counter is 8 bits.

Ports:
CLK  input  1  system clock, one CPU cycle per edge
RES  input  1  reset, asynchronous, active-high
cpu_a  input  16  CPU address bus
cpu_dout  input  8  CPU write data
cpu_rw  input  1  CPU direction, 1=read, 0=write
bus_din  input  8  read data returned from the system bus
rdy  output  1  CPU ready; 0 halts the CPU on its next read cycle
bus_a  output  16  arbitrated system address
bus_dout  output  8  arbitrated system write data
bus_rw  output  1  arbitrated direction, 1=read
dma_busy  output  1  1 from the trigger cycle+1 until the last write completes

Behaviour:
- Reset (async, RES=1): state=IDLE, rdy=1, dma_busy=0, parity=0, index=0, page=0, buf=0. Bus is in passthrough.
- parity: 1-bit register toggling every cycle after reset. parity=0 is a "get" (read) cycle; parity=1 is a "put" cycle.
- Passthrough (IDLE, WAIT_HALT, HALT, ALIGN): bus_a=cpu_a, bus_dout=cpu_dout, bus_rw=cpu_rw. This mux is combinational from the registered state.
- Trigger: in IDLE, a cycle T with cpu_rw=0 and cpu_a==DMA_REG_ADDR latches page<=cpu_dout, index<=0, and sets state<=WAIT_HALT. The write itself passes through to the bus. rdy=0 and dma_busy=1 from T+1.
- WAIT_HALT: if cpu_rw=1, this cycle is the halt cycle: go to ALIGN if the next cycle is a put (parity currently 0), else go to READ. If cpu_rw=0, the CPU is finishing write cycles: stay in WAIT_HALT. A further $4014 write here re-latches page.
- ALIGN: one idle cycle with passthrough, then go to READ.
- READ (always on a get cycle): bus_a={page,index}, bus_rw=1, bus_dout=8'h00. buf<=bus_din at the end of the cycle. Next state is WRITE.
- WRITE (put cycle): bus_a=OAM_DATA_ADDR, bus_dout=buf, bus_rw=0. If index==XFER_LEN-1, go to IDLE; otherwise index<=index+1 and go to READ. The index does not wrap across pages.
- Completion: rdy=1 and dma_busy=0 in the cycle after the final WRITE.
- Total rdy-low cycles with XFER_LEN=256 and no CPU write stalls: 513 if the trigger cycle T had parity 0, 514 if T had parity 1.
- $4014 writes while dma_busy=1 cannot occur except in WAIT_HALT (the CPU is halted elsewhere). Any that occur in other states are ignored.
- Reset mid-DMA: aborts immediately. rdy returns high asynchronously, and no further $2004 writes are issued.
- rdy, dma_busy and state are registered. Bus outputs are combinational from the registered state, page, index and buf.

Optional Feature:
OAM_DMA_STAT_EN: when defined, adds output dma_stall_cnt[15:0]. It counts every cycle with rdy=0, is cleared by RES, saturates at 16'hFFFF, and is readable by the debug harness. When undefined, the port and counter are absent and all other behaviour is identical.

Test Plan:
- Write 8'h02 to $4014 on a parity-0 cycle, CPU then reads -> rdy low exactly 513 cycles. Reads hit $0200..$02FF in order, writes hit $2004 with matching bytes, and dma_busy falls the same cycle rdy rises.
- Same write on a parity-1 cycle -> exactly one ALIGN cycle, 514 rdy-low cycles, and the first READ lands on parity 0.
- Trigger followed by two CPU write cycles (cpu_rw=0, as in an RMW instruction) -> state stays in WAIT_HALT for 2 cycles, those writes pass through unchanged, and the halt occurs on the first read.
- Assert RES during the 100th READ -> rdy=1 and dma_busy=0 immediately. No bus_rw=0 to $2004 after reset, and parity restarts at 0.
- XFER_LEN=4, page 8'hFF, memory preloaded with 8'hA5,8'h5A,8'h00,8'hFF -> exactly four $2004 writes of those values, 9 or 10 rdy-low cycles.
- With OAM_DMA_STAT_EN defined, run two back-to-back 256-byte DMAs (513 + 514) -> dma_stall_cnt == 1027.
